// File: rtl/hazard_ctrl_pkg.sv
// Shared types and sizing for the hazard scheduler: register ids, pending
// counters, the branch FSM encoding and the saturating stall counter helper.
package hazard_ctrl_pkg;

    localparam int NUM_REGS     = 16;
    localparam int REG_ID_WIDTH = 4;
    localparam int PEND_WIDTH   = 2;
    localparam int CNT_WIDTH    = 16;

    typedef logic [REG_ID_WIDTH-1:0] regId_t;
    typedef logic [PEND_WIDTH-1:0]   pend_t;
    typedef logic [CNT_WIDTH-1:0]    stallCnt_t;

    // Largest number of writes that may be in flight to one register.
    localparam pend_t PEND_MAX = '1;

    // Branch sequencing: idle, or a branch has issued and awaits resolution.
    typedef enum logic {
        BR_IDLE = 1'b0,
        BR_WAIT = 1'b1
    } brState_t;

    // A qualified register reference (source read, issue write or writeback).
    typedef struct packed {
        logic   en;
        regId_t regIdx;
    } regReq_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic stallCnt_t satIncr(stallCnt_t value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode / writeback / memory-stage signals into the hazard scheduler and the
// stall controls it returns to fetch. The pipeline side uses master, the
// scheduler uses slave.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    // Decode stage
    logic      I_DE_Valid;
    logic      I_DE_IsBranch;
    logic      I_DE_SrcAValid;
    regId_t    I_DE_SrcA;
    logic      I_DE_SrcBValid;
    regId_t    I_DE_SrcB;
    logic      I_DE_DestValid;
    regId_t    I_DE_DestReg;

    // Writeback stage
    logic      I_WB_Valid;
    regId_t    I_WB_DestReg;

    // Memory stage branch resolution
    logic      I_MEM_BranchResolved;
    logic      I_MEM_BranchTaken;

    // Results to fetch and status
    logic      O_DepStallSignal;
    logic      O_BranchStallSignal;
    logic      O_BranchAddrSelect;
    stallCnt_t O_StallCycles;
    logic      O_ScoreboardErr;
    logic      O_BranchErr;

    modport master (
        output I_DE_Valid, I_DE_IsBranch,
        output I_DE_SrcAValid, I_DE_SrcA, I_DE_SrcBValid, I_DE_SrcB,
        output I_DE_DestValid, I_DE_DestReg,
        output I_WB_Valid, I_WB_DestReg,
        output I_MEM_BranchResolved, I_MEM_BranchTaken,
        input  O_DepStallSignal, O_BranchStallSignal, O_BranchAddrSelect,
        input  O_StallCycles, O_ScoreboardErr, O_BranchErr
    );

    modport slave (
        input  I_DE_Valid, I_DE_IsBranch,
        input  I_DE_SrcAValid, I_DE_SrcA, I_DE_SrcBValid, I_DE_SrcB,
        input  I_DE_DestValid, I_DE_DestReg,
        input  I_WB_Valid, I_WB_DestReg,
        input  I_MEM_BranchResolved, I_MEM_BranchTaken,
        output O_DepStallSignal, O_BranchStallSignal, O_BranchAddrSelect,
        output O_StallCycles, O_ScoreboardErr, O_BranchErr
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard. Counts writes issued but not yet
// committed, reports read-after-write hazards for two decode sources with a
// same-cycle writeback bypass, and flags counter overflow/underflow.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic    I_CLOCK,
    input  logic    I_LOCK,
    input  regReq_t incReq,             // write issued from decode
    input  regReq_t decReq,             // write committed at writeback
    input  logic    suppressUnderflow,  // first cycle out of reset
    input  regReq_t srcAReq,
    input  regReq_t srcBReq,
    output logic    hazardA,
    output logic    hazardB,
    output logic    errEvent
);

    pend_t pending     [NUM_REGS];
    pend_t pendingNext [NUM_REGS];

    logic [NUM_REGS-1:0] incMask;
    logic [NUM_REGS-1:0] decMask;

    // A source waits while writes are pending, unless the only pending write
    // to it is being committed this very cycle.
    function automatic logic srcHazard(regReq_t src, pend_t cnt, regReq_t wb);
        return src.en && (cnt != '0)
               && !((cnt == pend_t'(1)) && wb.en && (wb.regIdx == src.regIdx));
    endfunction

    assign hazardA = srcHazard(srcAReq, pending[srcAReq.regIdx], decReq);
    assign hazardB = srcHazard(srcBReq, pending[srcBReq.regIdx], decReq);

    // Next pending counts with hold-on-saturation and error detection.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        errEvent = 1'b0;
        incMask  = incReq.en ? (NUM_REGS'(1) << incReq.regIdx) : '0;
        decMask  = decReq.en ? (NUM_REGS'(1) << decReq.regIdx) : '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pendingNext[i] = pending[i];
            case ({incMask[i], decMask[i]})
                2'b10: begin
                    if (pending[i] == PEND_MAX) errEvent = 1'b1;
                    else                        pendingNext[i] = pending[i] + 1'b1;
                end
                2'b01: begin
                    if (pending[i] == '0) errEvent = errEvent | !suppressUnderflow;
                    else                  pendingNext[i] = pending[i] - 1'b1;
                end
                default: ;  // idle, or issue and commit cancel out
            endcase
        end
    end

    // Pending counter register array.
    always_ff @(negedge I_CLOCK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!I_LOCK) begin
            // NOTE: this small array is reset on purpose: a stale nonzero
            // count would stall decode forever after reset.
            pending <= '{default: '0};
        end else begin
            pending <= pendingNext;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler feeding the fetch-stage stall inputs. Combines
// scoreboard dependency stalls with a branch-resolution FSM, and keeps a
// saturating stall-cycle counter plus sticky error flags.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input logic          I_CLOCK,
    input logic          I_LOCK,
    hazard_ctrl_if.slave hz
);

    brState_t  state;
    brState_t  stateNext;

    regReq_t   incReq;
    regReq_t   decReq;
    regReq_t   srcAReq;
    regReq_t   srcBReq;

    logic      hazardA;
    logic      hazardB;
    logic      sbErrEvent;
    logic      brErrEvent;
    logic      justReset;

    logic      depStall;
    logic      brStall;
    logic      addrSelect;
    logic      issue;

    stallCnt_t stallCycles;
    logic      sbErr;
    logic      brErr;

    assign srcAReq = '{en: hz.I_DE_SrcAValid, regIdx: hz.I_DE_SrcA};
    assign srcBReq = '{en: hz.I_DE_SrcBValid, regIdx: hz.I_DE_SrcB};
    assign decReq  = '{en: hz.I_WB_Valid,     regIdx: hz.I_WB_DestReg};
    assign incReq  = '{en: issue && hz.I_DE_DestValid, regIdx: hz.I_DE_DestReg};

    hazard_scoreboard u_scoreboard (
        .I_CLOCK           (I_CLOCK),
        .I_LOCK            (I_LOCK),
        .incReq            (incReq),
        .decReq            (decReq),
        .suppressUnderflow (justReset),
        .srcAReq           (srcAReq),
        .srcBReq           (srcBReq),
        .hazardA           (hazardA),
        .hazardB           (hazardB),
        .errEvent          (sbErrEvent)
    );

    // Fetch controls; all forced low while the block is held in reset.
    always_comb begin
        depStall   = I_LOCK && hz.I_DE_Valid && (hazardA || hazardB);
        issue      = I_LOCK && hz.I_DE_Valid && !depStall && (state != BR_WAIT);
        brStall    = I_LOCK && ((state == BR_WAIT) || (issue && hz.I_DE_IsBranch));
        addrSelect = I_LOCK && (state == BR_WAIT)
                     && hz.I_MEM_BranchResolved && hz.I_MEM_BranchTaken;
    end

    // Branch FSM next state; a resolve with nothing outstanding is an error.
    always_comb begin
        stateNext  = state;
        brErrEvent = 1'b0;
        case (state)
            BR_IDLE: begin
                if (hz.I_MEM_BranchResolved) brErrEvent = 1'b1;
                if (issue && hz.I_DE_IsBranch) stateNext = BR_WAIT;
            end
            BR_WAIT: begin
                if (hz.I_MEM_BranchResolved) stateNext = BR_IDLE;
            end
        endcase
    end

    // Branch FSM state register.
    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) state <= BR_IDLE;
        else         state <= stateNext;
    end

    // Stall counter, sticky errors and the post-reset writeback grace flag.
    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            stallCycles <= '0;
            sbErr       <= 1'b0;
            brErr       <= 1'b0;
            justReset   <= 1'b1;
        end else begin
            if (depStall || brStall) stallCycles <= satIncr(stallCycles);
            sbErr     <= sbErr | sbErrEvent;
            brErr     <= brErr | brErrEvent;
            justReset <= 1'b0;
        end
    end

    assign hz.O_DepStallSignal    = depStall;
    assign hz.O_BranchStallSignal = brStall;
    assign hz.O_BranchAddrSelect  = addrSelect;
    assign hz.O_StallCycles       = stallCycles;
    assign hz.O_ScoreboardErr     = sbErr;
    assign hz.O_BranchErr         = brErr;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. A behavioural model (integer pending
// counts, a "branch outstanding" bit, plain counters) predicts every output;
// each scenario task compares the DUT against it once per cycle.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef struct packed {
        bit       lock;
        bit       dv;
        bit       isBr;
        bit       av;
        bit [3:0] a;
        bit       bv;
        bit [3:0] b;
        bit       dstv;
        bit [3:0] dst;
        bit       wbv;
        bit [3:0] wbr;
        bit       res;
        bit       tk;
    } stim_t;

    logic clk = 1'b1;
    logic lock;
    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .I_CLOCK (clk),
        .I_LOCK  (lock),
        .hz      (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int    mPend [NUM_REGS];
    bit    mWait;
    int    mCnt;
    bit    mSbErr;
    bit    mBrErr;
    bit    mFresh;
    stim_t cur;
    stim_t seq [$];

    // ---------------- stimulus builders ----------------
    function automatic stim_t nop();
        stim_t s;
        s      = '0;
        s.lock = 1'b1;
        return s;
    endfunction

    function automatic stim_t ins(bit dstv, int dst, bit av, int a, bit bv, int b, bit isBr);
        stim_t s;
        s      = nop();
        s.dv   = 1'b1;
        s.dstv = dstv;
        s.dst  = 4'(dst);
        s.av   = av;
        s.a    = 4'(a);
        s.bv   = bv;
        s.b    = 4'(b);
        s.isBr = isBr;
        return s;
    endfunction

    function automatic stim_t withWb(stim_t s, int r);
        s.wbv = 1'b1;
        s.wbr = 4'(r);
        return s;
    endfunction

    function automatic stim_t withRes(stim_t s, bit taken);
        s.res = 1'b1;
        s.tk  = taken;
        return s;
    endfunction

    function automatic stim_t inReset(stim_t s);
        s.lock = 1'b0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        cur                      = s;
        lock                     = s.lock;
        bus.I_DE_Valid           = s.dv;
        bus.I_DE_IsBranch        = s.isBr;
        bus.I_DE_SrcAValid       = s.av;
        bus.I_DE_SrcA            = s.a;
        bus.I_DE_SrcBValid       = s.bv;
        bus.I_DE_SrcB            = s.b;
        bus.I_DE_DestValid       = s.dstv;
        bus.I_DE_DestReg         = s.dst;
        bus.I_WB_Valid           = s.wbv;
        bus.I_WB_DestReg         = s.wbr;
        bus.I_MEM_BranchResolved = s.res;
        bus.I_MEM_BranchTaken    = s.tk;
    endtask

    // ---------------- reference model ----------------
    function automatic bit mHaz(bit v, int r);
        return v && (mPend[r] > 0) && !(mPend[r] == 1 && cur.wbv && int'(cur.wbr) == r);
    endfunction

    function automatic bit mDep();
        return cur.lock && cur.dv && (mHaz(cur.av, int'(cur.a)) || mHaz(cur.bv, int'(cur.b)));
    endfunction

    function automatic bit mIssue();
        return cur.lock && cur.dv && !mDep() && !mWait;
    endfunction

    function automatic bit mBrStall();
        return cur.lock && (mWait || (mIssue() && cur.isBr));
    endfunction

    function automatic bit mSel();
        return cur.lock && mWait && cur.res && cur.tk;
    endfunction

    // {dep, branch stall, addr select, scoreboard err, branch err, stall count}
    function automatic logic [20:0] expVec();
        return {mDep(), mBrStall(), mSel(), mSbErr, mBrErr, 16'(mCnt)};
    endfunction

    function automatic logic [20:0] dutVec();
        return {bus.O_DepStallSignal, bus.O_BranchStallSignal, bus.O_BranchAddrSelect,
                bus.O_ScoreboardErr, bus.O_BranchErr, bus.O_StallCycles};
    endfunction

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic modelCommit();
        bit iss;
        bit inc;
        bit dec;
        int d;
        int w;
        if (!cur.lock) begin
            foreach (mPend[i]) mPend[i] = 0;
            mWait  = 1'b0;
            mCnt   = 0;
            mSbErr = 1'b0;
            mBrErr = 1'b0;
            mFresh = 1'b1;
            return;
        end
        iss = mIssue();
        if ((mDep() || mBrStall()) && mCnt < (1 << CNT_WIDTH) - 1) mCnt++;
        inc = iss && cur.dstv;
        dec = cur.wbv;
        d   = int'(cur.dst);
        w   = int'(cur.wbr);
        if (!(inc && dec && d == w)) begin
            if (inc) begin
                if (mPend[d] == (1 << PEND_WIDTH) - 1) mSbErr = 1'b1;
                else                                   mPend[d]++;
            end
            if (dec) begin
                if (mPend[w] == 0) begin
                    if (!mFresh) mSbErr = 1'b1;
                end else begin
                    mPend[w]--;
                end
            end
        end
        if (cur.res) begin
            if (mWait) mWait  = 1'b0;
            else       mBrErr = 1'b1;
        end
        if (iss && cur.isBr) mWait = 1'b1;
        mFresh = 1'b0;
    endtask

    task automatic tick();
        modelCommit();
        @(negedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(inReset(nop()));
        tick();
        seq.delete();
        seq.push_back(inReset(withRes(withWb(ins(1, 3, 1, 3, 1, 3, 1), 3), 1)));
        seq.push_back(nop());
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("FAIL reset step=%0d got=%h want=%h", k, dutVec(), expVec());
            end
            tick();
        end
    endtask

    task automatic test_dep_bypass();
        seq.delete();
        seq.push_back(inReset(nop()));
        seq.push_back(nop());
        seq.push_back(ins(1, 3, 0, 0, 0, 0, 0));
        repeat (3) seq.push_back(ins(0, 0, 1, 3, 0, 0, 0));
        seq.push_back(withWb(ins(0, 0, 1, 3, 0, 0, 0), 3));
        seq.push_back(ins(1, 9, 0, 0, 1, 9, 0));
        seq.push_back(ins(0, 0, 0, 0, 1, 9, 0));
        seq.push_back(withWb(nop(), 9));
        seq.push_back(nop());
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("FAIL dep_bypass step=%0d got=%h want=%h", k, dutVec(), expVec());
            end
            tick();
        end
    endtask

    task automatic test_branch_taken();
        seq.delete();
        seq.push_back(inReset(nop()));
        seq.push_back(nop());
        seq.push_back(ins(0, 0, 0, 0, 0, 0, 1));
        seq.push_back(ins(1, 6, 0, 0, 0, 0, 0));   // held back while waiting
        seq.push_back(nop());
        seq.push_back(withRes(nop(), 1));
        seq.push_back(ins(0, 0, 1, 6, 0, 0, 0));   // r6 never issued: no stall
        seq.push_back(nop());
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("FAIL branch_taken step=%0d got=%h want=%h", k, dutVec(), expVec());
            end
            tick();
        end
    endtask

    task automatic test_branch_not_taken();
        seq.delete();
        seq.push_back(inReset(nop()));
        seq.push_back(nop());
        seq.push_back(ins(1, 1, 0, 0, 0, 0, 1));
        seq.push_back(nop());
        seq.push_back(withRes(nop(), 0));
        seq.push_back(nop());
        seq.push_back(ins(0, 0, 1, 1, 0, 0, 0));
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("FAIL branch_not_taken step=%0d got=%h want=%h", k, dutVec(), expVec());
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        seq.delete();
        seq.push_back(inReset(nop()));
        seq.push_back(nop());
        repeat (4) seq.push_back(ins(1, 5, 0, 0, 0, 0, 0));
        seq.push_back(ins(0, 0, 1, 5, 0, 0, 0));
        repeat (2) seq.push_back(withWb(nop(), 5));
        seq.push_back(ins(0, 0, 1, 5, 0, 0, 0));
        seq.push_back(withWb(ins(0, 0, 1, 5, 0, 0, 0), 5));
        seq.push_back(ins(0, 0, 1, 5, 0, 0, 0));
        seq.push_back(inReset(nop()));
        seq.push_back(nop());
        seq.push_back(withWb(nop(), 5));           // underflow at zero
        seq.push_back(nop());
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("FAIL overflow step=%0d got=%h want=%h", k, dutVec(), expVec());
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        seq.delete();
        seq.push_back(inReset(nop()));
        seq.push_back(nop());
        seq.push_back(ins(1, 7, 0, 0, 0, 0, 0));
        seq.push_back(withWb(ins(1, 7, 0, 0, 0, 0, 0), 7));
        seq.push_back(ins(0, 0, 0, 0, 1, 7, 0));
        seq.push_back(withWb(ins(0, 0, 1, 7, 0, 0, 0), 7));
        seq.push_back(ins(0, 0, 1, 7, 0, 0, 0));
        seq.push_back(withRes(nop(), 1));          // resolve while idle
        seq.push_back(nop());
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("FAIL same_cycle step=%0d got=%h want=%h", k, dutVec(), expVec());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_branch();
        seq.delete();
        seq.push_back(inReset(nop()));
        seq.push_back(nop());
        seq.push_back(ins(1, 2, 0, 0, 0, 0, 0));
        seq.push_back(ins(1, 4, 0, 0, 0, 0, 0));
        seq.push_back(ins(0, 0, 0, 0, 0, 0, 1));
        seq.push_back(ins(0, 0, 1, 2, 0, 0, 0));
        seq.push_back(inReset(withRes(withWb(ins(0, 0, 1, 2, 0, 0, 0), 2), 1)));
        seq.push_back(withWb(ins(0, 0, 1, 4, 0, 0, 0), 4)); // dropped silently
        seq.push_back(ins(0, 0, 1, 2, 1, 4, 0));
        seq.push_back(withWb(nop(), 4));                    // now an error
        seq.push_back(nop());
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("FAIL reset_mid_branch step=%0d got=%h want=%h", k, dutVec(), expVec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int k = 0; k < 600; k++) begin
            s      = nop();
            s.lock = ($urandom_range(0, 39) != 0);
            s.dv   = ($urandom_range(0, 3) != 0);
            s.isBr = ($urandom_range(0, 7) == 0);
            s.av   = 1'($urandom_range(0, 1));
            s.a    = 4'($urandom_range(0, 3));
            s.bv   = 1'($urandom_range(0, 1));
            s.b    = 4'($urandom_range(0, 3));
            s.dstv = 1'($urandom_range(0, 1));
            s.dst  = 4'($urandom_range(0, 3));
            s.wbv  = ($urandom_range(0, 2) == 0);
            s.wbr  = 4'($urandom_range(0, 3));
            s.res  = ($urandom_range(0, 5) == 0);
            s.tk   = 1'($urandom_range(0, 1));
            drive(s);
            #2;
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("FAIL random cycle=%0d got=%h want=%h", k, dutVec(), expVec());
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        drive(inReset(nop()));
        tick();
        drive(ins(0, 0, 0, 0, 0, 0, 1));
        tick();
        for (int k = 0; k < 65540; k++) begin
            drive(nop());
            #2;
            if (k < 2 || k >= 65530) begin
                total++;
                if (dutVec() !== expVec()) begin
                    bad++;
                    $display("FAIL saturation cycle=%0d got=%h want=%h", k, dutVec(), expVec());
                end
            end
            tick();
        end
        drive(withRes(nop(), 1));
        #2;
        total++;
        if (dutVec() !== expVec()) begin
            bad++;
            $display("FAIL saturation_resolve got=%h want=%h", dutVec(), expVec());
        end
        tick();
        drive(nop());
        #2;
        total++;
        if (bus.O_StallCycles !== 16'hFFFF || dutVec() !== expVec()) begin
            bad++;
            $display("FAIL saturation_hold got=%h want=%h", dutVec(), expVec());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_dep_bypass();
        test_branch_taken();
        test_branch_not_taken();
        test_overflow();
        test_same_cycle();
        test_reset_mid_branch();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
